cksum_insert: RTL and testbench
===============================

# cksum_insert

Transmit-side companion of the header checksum calculator. It captures a packet header, computes the 16-bit ones'-complement checksum over a byte range with the checksum field treated as zero, and writes the result big-endian into the header copy. The deparser/egress path uses it to emit headers with valid IPv4/UDP-style checksums.

## Interface

Parameters (from `def.svh`):
- `HDR_MAX_LEN`, 64: header buffer depth in bytes.
- `BYTE_BUS` / `HALF_BUS` / `DATA_BUS` / `ADDR_BUS`, —: 8 / 16 / 32-bit / byte-address bus ranges.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; accepted only in IDLE.
- `pkt_hdr_i`  in  `BYTE_BUS` x `HDR_MAX_LEN`  header bytes, sampled on the accept cycle.
- `field_start_i`  in  `ADDR_BUS`  first byte of the summed range.
- `field_len_i`  in  `DATA_BUS`  range length in bytes; odd lengths allowed.
- `cksum_pos_i`  in  `ADDR_BUS`  checksum high byte position; low byte at +1.
- `busy_o`  out  1  high from the cycle after accept through the DONE cycle.
- `done_o`  out  1  one-cycle completion pulse.
- `cksum_val_o`  out  `HALF_BUS`  final checksum, held until next accept.
- `pkt_hdr_o`  out  `BYTE_BUS` x `HDR_MAX_LEN`  header with checksum inserted; valid from `done_o`, held until next accept.

## Operation

- States: IDLE, SUM, FOLD, WRITE.
- IDLE + `start_i`:
  - copy `pkt_hdr_i` to the internal buffer;
  - latch addr = `field_start_i`, end = `field_start_i + field_len_i`, and `cksum_pos_i`;
  - clear the 32-bit accumulator;
  - go to SUM.
- SUM: each cycle, while addr < end, add {byte[addr], byte[addr+1]} and advance addr by 2.
  - A byte reads as 0x00 if its index ≥ end, ≥ `HDR_MAX_LEN`, or equals `cksum_pos` or `cksum_pos`+1.
  - So an odd final byte is padded low with zero.
  - When addr ≥ end, go to FOLD.
- FOLD: acc ← acc[31:16] + acc[15:0], then go to WRITE.
- WRITE:
  - cksum = ~(acc[31:16] + acc[15:0]) truncated to 16 bits;
  - buffer[pos] ← cksum[15:8] and buffer[pos+1] ← cksum[7:0], each write skipped if its index ≥ `HDR_MAX_LEN`;
  - `cksum_val_o` updated; `done_o` = 1; return to IDLE.
- The 32-bit accumulator cannot overflow for `HDR_MAX_LEN` ≤ 65536; two folds always suffice.
- `start_i` outside IDLE: ignored, with no queuing.
- `field_len_i` = 0: SUM lasts zero add cycles and the result is 0xFFFF.

## Timing

- Accept at cycle 0 with length L; N = ceil(L/2).
- SUM adds occupy cycles 1..N; the exit check is at cycle N+1.
- FOLD runs at N+2; WRITE, `done_o`, and output update occur at N+3.
- A new start is accepted no earlier than cycle N+4.
- Reset values: `busy_o` = 0, `done_o` = 0, `cksum_val_o` = 0x0000, `pkt_hdr_o` all 0x00, state IDLE, accumulator 0.
- Reset mid-operation aborts immediately with no `done_o` pulse.
- Reset has priority over `start_i` in the same cycle.

## Configuration

- `CKSUM_VERIFY_EN` defined:
  - adds input `verify_i` (sampled at accept) and output `cksum_ok_o` (reset 0, updated at WRITE, held).
  - With `verify_i` = 1, checksum bytes are not masked, the buffer is not written, and `cksum_ok_o` = (computed cksum == 0x0000).
  - With `verify_i` = 0, behaviour is insert mode and `cksum_ok_o` = 0.
- Not defined: neither port exists; insert mode only.

## Structure

- `cksum_pkg`: state enum `cksum_state_t`, `CKSUM_ZERO` = 16'h0000, `CKSUM_GOOD` = 16'h0000 verify target; width macros stay in `def.svh`.
- Sub-module `cksum_fold`: combinational 32→16 end-around-carry fold with optional complement, used in FOLD and WRITE.

## Test plan

- IPv4 header 45 00 00 73 00 00 40 00 40 11 12 34 c0 a8 00 01 c0 a8 00 c7; start 0, len 20, pos 10 -> `cksum_val_o` = 0xB861, bytes 10/11 = B8/61, `done_o` at cycle 13, other bytes unchanged.
- Same header with B8 61 at 10/11, `verify_i` = 1 (`CKSUM_VERIFY_EN`) -> `cksum_ok_o` = 1, buffer unchanged; flip byte 3 to 0x74 -> `cksum_ok_o` = 0.
- Bytes 01 02 03, len 3, pos 4 -> 0xFBFD at bytes 4/5, `done_o` at cycle 5.
- Bytes FF FF FF FF, len 4, pos 4 -> sum 0x1FFFE folds to 0xFFFF, checksum 0x0000.
- len 0 -> 0xFFFF, `done_o` at cycle 3.
- `start_i` pulsed during SUM -> ignored, single `done_o`; `rst` at cycle 2 -> no `done_o`, all outputs zero, next start completes normally.

Source files
------------

// File: rtl/cksum_pkg.sv
// cksum_pkg: shared widths, FSM states and checksum constants for cksum_insert
package cksum_pkg;
  localparam int HDR_MAX_LEN = 64;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int HDR_AW = $clog2(HDR_MAX_LEN);
  localparam logic [15:0] CKSUM_ZERO = 16'h0000;
  localparam logic [15:0] CKSUM_GOOD = 16'h0000;
  typedef enum logic [1:0] {IDLE, SUM, FOLD, WRITE} cksum_state_t;
endpackage

// File: rtl/cksum_fold.sv
// cksum_fold: 32->16 fold (a[31:16]+a[15:0]) with carry out c and optional complement of the low 16 bits
module cksum_fold (
  input  logic [31:0] a,
  input  logic        inv,
  output logic [15:0] y,
  output logic        c
);
  logic [16:0] s;
  always_comb begin
    s = {1'b0, a[31:16]} + {1'b0, a[15:0]};
    y = inv ? ~s[15:0] : s[15:0];
    c = s[16];
  end
endmodule

// File: rtl/cksum_insert.sv
// cksum_insert: header checksum calc + big-endian insert (clk/rst, start_i, pkt_hdr_i, field_start_i, field_len_i, cksum_pos_i -> busy_o, done_o, cksum_val_o, pkt_hdr_o); CKSUM_VERIFY_EN adds verify_i/cksum_ok_o
module cksum_insert
  import cksum_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]   pkt_hdr_i,
  input  logic [ADDR_W-1:0]                    field_start_i,
  input  logic [DATA_W-1:0]                    field_len_i,
  input  logic [ADDR_W-1:0]                    cksum_pos_i,
`ifdef CKSUM_VERIFY_EN
  input  logic                                 verify_i,
  output logic                                 cksum_ok_o,
`endif
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [HALF_W-1:0]                    cksum_val_o,
  output logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]   pkt_hdr_o
);
  localparam int IW = DATA_W + 1;
  localparam logic [IW-1:0] LIM = IW'(HDR_MAX_LEN);
  cksum_state_t state, state_nx;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] hdr;
  logic [IW-1:0] addr, fin, pos_hi, pos_lo;
  logic [31:0] acc;
  logic [BYTE_W-1:0] b0, b1;
  logic [15:0] f1, cks;
  logic c1, unused_c2;
  logic vfy;
  logic accept;

  function automatic logic [BYTE_W-1:0] rd(
    input logic [IW-1:0] i,
    input logic [IW-1:0] e,
    input logic [IW-1:0] ph,
    input logic [IW-1:0] pl,
    input logic m,
    input logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] h
  );
    rd = (i >= e || i >= LIM || (m && (i == ph || i == pl))) ? '0 : h[i[HDR_AW-1:0]];
  endfunction

  assign accept = state == IDLE && start_i;
  assign b0 = rd(addr, fin, pos_hi, pos_lo, !vfy, hdr);
  assign b1 = rd(addr + IW'(1), fin, pos_hi, pos_lo, !vfy, hdr);
  assign pkt_hdr_o = hdr;

  cksum_fold u_fold_acc (.a(acc), .inv(1'b0), .y(f1), .c(c1));
  cksum_fold u_fold_out (.a({15'h0, c1, f1}), .inv(1'b1), .y(cks), .c(unused_c2));

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (start_i ? SUM : IDLE)
             : state == SUM  ? (addr >= fin ? FOLD : SUM)
             : state == FOLD ? WRITE : IDLE;
    busy_o = state != IDLE;
    done_o = state == WRITE;
  end

  // The complemented result is formed from the first fold while it is being
  // stored, so the header and checksum are already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr <= '0;
      addr <= '0;
      fin <= '0;
      pos_hi <= '0;
      pos_lo <= '0;
      acc <= '0;
      cksum_val_o <= CKSUM_ZERO;
    end else begin
      if (accept) begin
        hdr <= pkt_hdr_i;
        addr <= IW'(field_start_i);
        fin <= IW'(field_start_i) + IW'(field_len_i);
        pos_hi <= IW'(cksum_pos_i);
        pos_lo <= IW'(cksum_pos_i) + IW'(1);
        acc <= '0;
      end
      if (state == SUM && addr < fin) begin
        acc <= acc + {16'h0, b0, b1};
        addr <= addr + IW'(2);
      end
      if (state == FOLD) begin
        acc <= {15'h0, c1, f1};
        cksum_val_o <= cks;
        if (!vfy && pos_hi < LIM) hdr[pos_hi[HDR_AW-1:0]] <= cks[15:8];
        if (!vfy && pos_lo < LIM) hdr[pos_lo[HDR_AW-1:0]] <= cks[7:0];
      end
    end
  end

`ifdef CKSUM_VERIFY_EN
  always_ff @(posedge clk)
    if (rst) begin
      vfy <= 1'b0;
      cksum_ok_o <= 1'b0;
    end else begin
      if (accept) vfy <= verify_i;
      if (state == FOLD) cksum_ok_o <= vfy && cks == CKSUM_GOOD;
    end
`else
  assign vfy = 1'b0;
`endif
endmodule

// File: tb/tb_cksum_insert.sv
// tb_cksum_insert: randomized and directed self-check of cksum_insert against a byte-level reference model
module tb_cksum_insert;
  logic clk = 0;
  logic rst = 1;
  logic start_i = 0;
  logic [63:0][7:0] pkt_hdr_i = '0;
  logic [63:0][7:0] pkt_hdr_o;
  logic [15:0] field_start_i = 0;
  logic [15:0] cksum_pos_i = 0;
  logic [15:0] cksum_val_o;
  logic [31:0] field_len_i = 0;
  logic busy_o, done_o;
`ifdef CKSUM_VERIFY_EN
  logic verify_i = 0;
  logic cksum_ok_o;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] ip [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                          8'h12, 8'h34, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
  logic [63:0][7:0] ip_h;

  cksum_insert dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
    .field_start_i(field_start_i), .field_len_i(field_len_i), .cksum_pos_i(cksum_pos_i),
`ifdef CKSUM_VERIFY_EN
    .verify_i(verify_i), .cksum_ok_o(cksum_ok_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .cksum_val_o(cksum_val_o), .pkt_hdr_o(pkt_hdr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ones'-complement sum of the byte range as big-endian 16-bit words, folded until no carry remains.
  function automatic logic [15:0] ref_cksum(input logic [63:0][7:0] h, input int st, input int ln,
                                            input int ps, input bit vf);
    longint s = 0;
    int b;
    for (int i = st; i < st + ln; i++) begin
      b = (i >= 64 || (!vf && (i == ps || i == ps + 1))) ? 0 : int'(h[i[5:0]]);
      s += ((i - st) % 2 == 0) ? b * 256 : b;
    end
    while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic run(input logic [63:0][7:0] h, input int st, input int ln, input int ps,
                     input bit vf, input string tag);
    logic [15:0] exp_c;
    logic [63:0][7:0] exp_h;
    int cyc;
    exp_c = ref_cksum(h, st, ln, ps, vf);
    exp_h = h;
    if (!vf && ps < 64) exp_h[ps] = exp_c[15:8];
    if (!vf && ps + 1 < 64) exp_h[ps + 1] = exp_c[7:0];
    pkt_hdr_i = h;
    field_start_i = 16'(st);
    field_len_i = 32'(ln);
    cksum_pos_i = 16'(ps);
`ifdef CKSUM_VERIFY_EN
    verify_i = vf;
`endif
    start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    check({tag, "_busy1"}, 512'(busy_o), 512'(1));
    cyc = 1;
    while (!done_o && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_cyc"}, 512'(cyc), 512'((ln + 1) / 2 + 3));
    check({tag, "_ck"}, 512'(cksum_val_o), 512'(exp_c));
    check({tag, "_hdr"}, 512'(pkt_hdr_o), 512'(exp_h));
    check({tag, "_busyd"}, 512'(busy_o), 512'(1));
`ifdef CKSUM_VERIFY_EN
    check({tag, "_ok"}, 512'(cksum_ok_o), 512'(vf && exp_c == 16'h0000));
`endif
    @(posedge clk);
    #1 check({tag, "_idle"}, 512'({busy_o, done_o}), 512'(0));
    check({tag, "_hold"}, 512'(cksum_val_o), 512'(exp_c));
  endtask

  initial begin
    logic [63:0][7:0] h;
    int dones;
    ip_h = '0;
    for (int i = 0; i < 20; i++) ip_h[i] = ip[i];
    repeat (3) @(posedge clk);
    #1 check("rst_state", 512'({busy_o, done_o, cksum_val_o}), 512'(0));
    check("rst_hdr", 512'(pkt_hdr_o), 512'(0));
    start_i = 1;
    pkt_hdr_i = ip_h;
    @(posedge clk);
    #1 rst = 0;
    start_i = 0;
    check("rst_prio", 512'(busy_o), 512'(0));

    run(ip_h, 0, 20, 10, 0, "ipv4");
    check("ipv4_const", 512'(cksum_val_o), 512'(16'hB861));
`ifdef CKSUM_VERIFY_EN
    h = ip_h;
    h[10] = 8'hB8;
    h[11] = 8'h61;
    run(h, 0, 20, 10, 1, "vfy_good");
    h[3] = 8'h74;
    run(h, 0, 20, 10, 1, "vfy_bad");
`endif
    h = '0;
    h[0] = 8'h01;
    h[1] = 8'h02;
    h[2] = 8'h03;
    run(h, 0, 3, 4, 0, "odd3");
    check("odd3_const", 512'(cksum_val_o), 512'(16'hFBFD));
    h = '0;
    for (int i = 0; i < 4; i++) h[i] = 8'hFF;
    run(h, 0, 4, 4, 0, "ffff");
    check("ffff_const", 512'(cksum_val_o), 512'(16'h0000));
    run(ip_h, 0, 0, 10, 0, "len0");
    check("len0_const", 512'(cksum_val_o), 512'(16'hFFFF));
    h = ip_h;
    run(h, 60, 4, 63, 0, "edge");

    pkt_hdr_i = ip_h;
    field_start_i = 0;
    field_len_i = 20;
    cksum_pos_i = 10;
    start_i = 1;
    @(posedge clk);
    #1 field_len_i = 2;
    cksum_pos_i = 30;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) start_i = 0;
      dones += int'(done_o);
      @(posedge clk);
      #1;
    end
    check("ign_dones", 512'(dones), 512'(1));
    check("ign_ck", 512'(cksum_val_o), 512'(16'hB861));

    start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("abort_state", 512'({busy_o, done_o, cksum_val_o}), 512'(0));
    check("abort_hdr", 512'(pkt_hdr_o), 512'(0));
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      dones += int'(done_o);
      @(posedge clk);
      #1;
    end
    check("abort_dones", 512'(dones), 512'(0));
    run(ip_h, 0, 20, 10, 0, "after_rst");

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 64; k++) h[k] = 8'($urandom);
      run(h, int'($urandom_range(0, 63)), int'($urandom_range(0, 70)), int'($urandom_range(0, 65)),
`ifdef CKSUM_VERIFY_EN
          bit'($urandom_range(0, 1)),
`else
          1'b0,
`endif
          "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
